// File: rtl/core_avl_arbiter.sv
// Two-master Avalon-MM arbiter: instruction fetch (m0) and load/store (m1) share one
// slave port, with round-robin tie-break and a single outstanding transaction.
module core_avl_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rest,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;

  logic                req0, req1;
  logic                own_read, own_write;
  logic [ADDR_W-1:0]   own_address;
  logic [DATA_W-1:0]   own_writedata;
  logic [DATA_W/8-1:0] own_byteenable;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    own_read       = owner_q ? m1_read       : m0_read;
    own_write      = owner_q ? m1_write      : m0_write;
    own_address    = owner_q ? m1_address    : m0_address;
    own_writedata  = owner_q ? m1_writedata  : m0_writedata;
    own_byteenable = owner_q ? m1_byteenable : m0_byteenable;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          owner_d = ~last_q;
          last_d  = ~last_q;
          state_d = CMD;
        end else if (req0) begin
          owner_d = 1'b0;
          state_d = CMD;
        end else if (req1) begin
          owner_d = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        // A write wins over a simultaneous read, so it never waits for read data.
        if (!own_read && !own_write) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = own_write ? IDLE : RDWAIT;
        end
      end
      RDWAIT: begin
        if (s_readdatavalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_read           = 1'b0;
    s_write          = 1'b0;
    s_address        = '0;
    s_writedata      = '0;
    s_byteenable     = '0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    if (state_q == CMD) begin
      s_read       = own_read & ~own_write;
      s_write      = own_write;
      s_address    = own_address;
      s_writedata  = own_writedata;
      s_byteenable = own_byteenable;
      if (owner_q) m1_waitrequest = s_waitrequest;
      else         m0_waitrequest = s_waitrequest;
    end
    if (state_q == RDWAIT) begin
      m0_readdatavalid = s_readdatavalid & ~owner_q;
      m1_readdatavalid = s_readdatavalid &  owner_q;
    end
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_core_avl_arbiter.sv
// Scoreboard bench for core_avl_arbiter: expected slave commands and read data are
// queued as stimulus is driven and popped when the DUT presents them.
module tb_core_avl_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rest = 1'b1;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;

  core_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rest(rest),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmd_t;

  typedef struct {
    int rd_cyc; int wr_cyc; int rdv0; int rdv1;
    int w0_low; int w1_low; int mirr_err; int wr_changes;
  } stats_t;

  cmd_t              exp_cmd[$];
  logic [DATA_W-1:0] exp_rd0[$], exp_rd1[$], slave_rq[$];
  int                grant_who[$], grant_cyc[$];
  int                vectors = 0, miscompares = 0;
  cmd_t              mon_e;
  logic [DATA_W-1:0] mon_d;
  stats_t            st;

  // Scoreboard side: slave command acceptance and master read-data strobes.
  always @(negedge clk) begin
    if (rest && (s_read || s_write) && !s_waitrequest) begin
      vectors++;
      if (exp_cmd.size() == 0) begin
        miscompares++;
        $display("FAIL slave_cmd: got rd=%0b wr=%0b addr=%h, required no command", s_read, s_write, s_address);
      end else begin
        mon_e = exp_cmd.pop_front();
        if ({s_read, s_write, s_address, s_writedata, s_byteenable} !== mon_e) begin
          miscompares++;
          $display("FAIL slave_cmd: got rd=%0b wr=%0b addr=%h data=%h be=%h, required rd=%0b wr=%0b addr=%h data=%h be=%h",
                   s_read, s_write, s_address, s_writedata, s_byteenable,
                   mon_e.rd, mon_e.wr, mon_e.addr, mon_e.data, mon_e.be);
        end
      end
    end
    if (m0_readdatavalid) begin
      vectors++;
      if (exp_rd0.size() == 0) begin
        miscompares++;
        $display("FAIL m0_rdata: got strobe with %h, required no strobe", m0_readdata);
      end else begin
        mon_d = exp_rd0.pop_front();
        if (m0_readdata !== mon_d) begin
          miscompares++;
          $display("FAIL m0_rdata: got %h, required %h", m0_readdata, mon_d);
        end
      end
    end
    if (m1_readdatavalid) begin
      vectors++;
      if (exp_rd1.size() == 0) begin
        miscompares++;
        $display("FAIL m1_rdata: got strobe with %h, required no strobe", m1_readdata);
      end else begin
        mon_d = exp_rd1.pop_front();
        if (m1_readdata !== mon_d) begin
          miscompares++;
          $display("FAIL m1_rdata: got %h, required %h", m1_readdata, mon_d);
        end
      end
    end
    if (s_readdatavalid) begin
      vectors++;
      if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin
        miscompares++;
        $display("FAIL rdata_fanout: got m0=%h m1=%h, required %h", m0_readdata, m1_readdata, s_readdata);
      end
    end
  end

  // Runs masters and slave until all commands retire; master drops its command
  // on the edge after acceptance, slave stalls each command `stall` cycles.
  task automatic serve(input int stall, input int lat, input int max_cyc, output stats_t so);
    int st_rem, pend;
    logic acc0, acc1, s_acc_rd, done, prev_wr;
    logic [ADDR_W-1:0] prev_a;
    logic [DATA_W-1:0] prev_d;
    so = '{default: 0};
    st_rem = stall; pend = 0; done = 1'b0; prev_wr = 1'b0; prev_a = '0; prev_d = '0;
    s_waitrequest = (stall > 0);
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk);
      if (!m0_read && !m0_write && !m1_read && !m1_write && pend == 0 && !s_readdatavalid) begin
        done = 1'b1;
      end else begin
        acc0 = (m0_read || m0_write) && !m0_waitrequest;
        acc1 = (m1_read || m1_write) && !m1_waitrequest;
        s_acc_rd = s_read && !s_waitrequest;
        if (s_read) so.rd_cyc++;
        if (s_write) so.wr_cyc++;
        if (m0_readdatavalid) so.rdv0++;
        if (m1_readdatavalid) so.rdv1++;
        if (!m0_waitrequest) so.w0_low++;
        if (!m1_waitrequest) so.w1_low++;
        if ((s_read || s_write) && ((m0_waitrequest && m1_waitrequest) != s_waitrequest)) so.mirr_err++;
        if (s_write && prev_wr && (s_address != prev_a || s_writedata != prev_d)) so.wr_changes++;
        prev_wr = s_write; prev_a = s_address; prev_d = s_writedata;
        if (s_read || s_write) begin
          if (s_waitrequest) begin
            if (st_rem > 0) st_rem--;
          end else begin
            st_rem = stall;
          end
        end
        @(posedge clk); #1;
        if (acc0) begin m0_read = 1'b0; m0_write = 1'b0; grant_who.push_back(0); grant_cyc.push_back(cyc); end
        if (acc1) begin m1_read = 1'b0; m1_write = 1'b0; grant_who.push_back(1); grant_cyc.push_back(cyc); end
        s_readdatavalid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            s_readdatavalid = 1'b1;
            s_readdata = (slave_rq.size() != 0) ? slave_rq.pop_front() : '0;
          end
        end
        if (s_acc_rd) pend = lat;
        s_waitrequest = (st_rem > 0);
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL serve_timeout: got no completion within %0d cycles, required completion", max_cyc);
    end
  endtask

  task automatic apply_reset;
    rest = 1'b1;
    #2 rest = 1'b0;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_readdatavalid = 1'b0; s_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 rest = 1'b1;
  endtask

  task automatic test_reset;
    rest = 1'b1;
    #2 rest = 1'b0;
    m0_read = 1'b1; m0_address = 32'h123; m1_write = 1'b1; m1_writedata = 32'h99;
    m1_byteenable = 4'hF; s_readdatavalid = 1'b1; s_waitrequest = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100) begin
        miscompares++;
        $display("FAIL reset_outputs: got rd,wr,wq0,wq1,rdv0,rdv1=%b, required 001100",
                 {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
      end
    end
    @(posedge clk); #1;
    m0_read = 1'b0; m1_write = 1'b0; s_readdatavalid = 1'b0;
    rest = 1'b1;
    @(negedge clk);
    vectors++;
    if ({s_read, s_write, s_address, s_writedata, s_byteenable, m0_waitrequest, m1_waitrequest} !==
        {2'b00, 32'h0, 32'h0, 4'h0, 2'b11}) begin
      miscompares++;
      $display("FAIL idle_outputs: got rd=%0b wr=%0b addr=%h data=%h be=%h wq=%0b%0b, required all zero, wq=11",
               s_read, s_write, s_address, s_writedata, s_byteenable, m0_waitrequest, m1_waitrequest);
    end
  endtask

  task automatic test_single_read;
    @(posedge clk); #1;
    grant_cyc.delete(); grant_who.delete();
    exp_cmd.push_back(cmd_t'{1'b1, 1'b0, 32'h100, 32'h0, 4'hF});
    slave_rq.push_back(32'hDEADBEEF);
    exp_rd0.push_back(32'hDEADBEEF);
    m0_address = 32'h100; m0_writedata = '0; m0_byteenable = 4'hF; m0_read = 1'b1;
    s_waitrequest = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_read, m0_waitrequest, s_address} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL read_latency_idle: got s_read=%0b wq0=%0b addr=%h, required 0 1 0", s_read, m0_waitrequest, s_address);
    end
    @(posedge clk); #1;
    serve(0, 2, 50, st);
    vectors++;
    if (st.rd_cyc != 1 || st.rdv0 != 1 || st.rdv1 != 0 || st.w1_low != 0) begin
      miscompares++;
      $display("FAIL single_read: got rd_cyc=%0d rdv0=%0d rdv1=%0d w1_low=%0d, required 1 1 0 0", st.rd_cyc, st.rdv0, st.rdv1, st.w1_low);
    end
    vectors++;
    if (grant_cyc.size() != 1 || grant_cyc[0] != 0) begin
      miscompares++;
      $display("FAIL read_latency_cmd: got %0d grants, first at cycle %0d, required one at cycle 0",
               grant_cyc.size(), (grant_cyc.size() != 0) ? grant_cyc[0] : -1);
    end
  endtask

  task automatic test_tie;
    apply_reset();
    grant_who.delete(); grant_cyc.delete();
    exp_cmd.push_back(cmd_t'{1'b1, 1'b0, 32'h10, 32'h0, 4'hF});
    exp_cmd.push_back(cmd_t'{1'b1, 1'b0, 32'h20, 32'h0, 4'hF});
    slave_rq.push_back(32'h1111_0010); slave_rq.push_back(32'h2222_0020);
    exp_rd0.push_back(32'h1111_0010); exp_rd1.push_back(32'h2222_0020);
    m0_address = 32'h10; m0_writedata = '0; m0_byteenable = 4'hF; m0_read = 1'b1;
    m1_address = 32'h20; m1_writedata = '0; m1_byteenable = 4'hF; m1_read = 1'b1;
    serve(0, 1, 100, st);
    vectors++;
    if (grant_who.size() != 2) begin
      miscompares++;
      $display("FAIL tie_first: got %0d grants, required 2", grant_who.size());
    end else if (grant_who[0] != 0 || grant_who[1] != 1) begin
      miscompares++;
      $display("FAIL tie_first: got order %0d,%0d, required 0,1", grant_who[0], grant_who[1]);
    end
    @(posedge clk); #1;
    grant_who.delete(); grant_cyc.delete();
    exp_cmd.push_back(cmd_t'{1'b0, 1'b1, 32'h40, 32'h4, 4'hF});
    exp_cmd.push_back(cmd_t'{1'b0, 1'b1, 32'h30, 32'h3, 4'h1});
    m0_address = 32'h30; m0_writedata = 32'h3; m0_byteenable = 4'h1; m0_write = 1'b1;
    m1_address = 32'h40; m1_writedata = 32'h4; m1_byteenable = 4'hF; m1_write = 1'b1;
    serve(0, 1, 100, st);
    vectors++;
    if (grant_who.size() != 2) begin
      miscompares++;
      $display("FAIL tie_second: got %0d grants, required 2", grant_who.size());
    end else if (grant_who[0] != 1 || grant_who[1] != 0 || grant_cyc[1] - grant_cyc[0] != 2) begin
      miscompares++;
      $display("FAIL tie_second: got order %0d,%0d spacing %0d, required 1,0 spacing 2",
               grant_who[0], grant_who[1], grant_cyc[1] - grant_cyc[0]);
    end
  endtask

  task automatic test_write_stall;
    @(posedge clk); #1;
    exp_cmd.push_back(cmd_t'{1'b0, 1'b1, 32'h200, 32'h55, 4'h3});
    m1_address = 32'h200; m1_writedata = 32'h55; m1_byteenable = 4'h3; m1_write = 1'b1;
    serve(3, 1, 50, st);
    vectors++;
    if (st.wr_cyc != 4 || st.wr_changes != 0 || st.mirr_err != 0 || st.w0_low != 0 || st.w1_low != 1) begin
      miscompares++;
      $display("FAIL write_stall: got wr_cyc=%0d changes=%0d mirror_err=%0d w0_low=%0d w1_low=%0d, required 4 0 0 0 1",
               st.wr_cyc, st.wr_changes, st.mirr_err, st.w0_low, st.w1_low);
    end
  endtask

  task automatic test_rw_both;
    @(posedge clk); #1;
    exp_cmd.push_back(cmd_t'{1'b0, 1'b1, 32'h300, 32'hA5A5, 4'hF});
    m1_address = 32'h300; m1_writedata = 32'hA5A5; m1_byteenable = 4'hF;
    m1_read = 1'b1; m1_write = 1'b1;
    serve(0, 1, 50, st);
    vectors++;
    if (st.rd_cyc != 0 || st.wr_cyc != 1 || st.rdv1 != 0) begin
      miscompares++;
      $display("FAIL read_write_both: got rd_cyc=%0d wr_cyc=%0d rdv1=%0d, required 0 1 0", st.rd_cyc, st.wr_cyc, st.rdv1);
    end
  endtask

  task automatic test_spurious;
    @(posedge clk); #1;
    s_readdatavalid = 1'b1; s_readdata = 32'hBAD0BAD0; s_waitrequest = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest, s_read, s_write} !== 6'b001100) begin
        miscompares++;
        $display("FAIL spurious_idle: got rdv0,rdv1,wq0,wq1,rd,wr=%b, required 001100",
                 {m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest, s_read, s_write});
      end
      @(posedge clk); #1;
    end
    exp_cmd.push_back(cmd_t'{1'b0, 1'b1, 32'h500, 32'h77, 4'hF});
    m0_address = 32'h500; m0_writedata = 32'h77; m0_byteenable = 4'hF; m0_write = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({m0_readdatavalid, m1_readdatavalid, s_write, m0_waitrequest} !== 4'b0011) begin
        miscompares++;
        $display("FAIL spurious_cmd: got rdv0,rdv1,wr,wq0=%b, required 0011",
                 {m0_readdatavalid, m1_readdatavalid, s_write, m0_waitrequest});
      end
      @(posedge clk); #1;
    end
    s_readdatavalid = 1'b0;
    serve(0, 1, 50, st);
  endtask

  task automatic test_reset_rdwait;
    @(posedge clk); #1;
    exp_cmd.push_back(cmd_t'{1'b1, 1'b0, 32'h400, 32'h0, 4'hF});
    m1_address = 32'h400; m1_writedata = '0; m1_byteenable = 4'hF; m1_read = 1'b1;
    s_waitrequest = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_read, s_write, m1_waitrequest, m1_readdatavalid} !== 4'b0010) begin
      miscompares++;
      $display("FAIL rdwait_outputs: got rd,wr,wq1,rdv1=%b, required 0010", {s_read, s_write, m1_waitrequest, m1_readdatavalid});
    end
    #2 rest = 1'b0;
    @(posedge clk); #3 rest = 1'b1;
    @(posedge clk); #1;
    s_readdatavalid = 1'b1; s_readdata = 32'hCAFE0400;
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL late_rdv: got rdv0,rdv1=%b, required 00", {m0_readdatavalid, m1_readdatavalid});
    end
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
    grant_who.delete(); grant_cyc.delete();
    exp_cmd.push_back(cmd_t'{1'b1, 1'b0, 32'h600, 32'h0, 4'hF});
    slave_rq.push_back(32'h0600_0600); exp_rd1.push_back(32'h0600_0600);
    m1_address = 32'h600; m1_read = 1'b1;
    serve(0, 1, 50, st);
    vectors++;
    if (grant_cyc.size() != 1 || grant_cyc[0] != 1 || st.rdv1 != 1) begin
      miscompares++;
      $display("FAIL post_reset_grant: got %0d grants rdv1=%0d, required one grant at cycle 1 and rdv1=1", grant_cyc.size(), st.rdv1);
    end
  endtask

  task automatic test_drop;
    @(posedge clk); #1;
    m0_address = 32'h700; m0_writedata = '0; m0_byteenable = 4'hF; m0_read = 1'b1;
    s_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({s_read, m0_waitrequest} !== 2'b11) begin
      miscompares++;
      $display("FAIL drop_stalled: got rd,wq0=%b, required 11", {s_read, m0_waitrequest});
    end
    @(posedge clk); #1;
    m0_read = 1'b0; s_waitrequest = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_read, s_write} !== 2'b00) begin
      miscompares++;
      $display("FAIL drop_no_cmd: got rd,wr=%b, required 00", {s_read, s_write});
    end
    @(posedge clk); #1;
    grant_who.delete(); grant_cyc.delete();
    exp_cmd.push_back(cmd_t'{1'b0, 1'b1, 32'h800, 32'h88, 4'hF});
    m1_address = 32'h800; m1_writedata = 32'h88; m1_byteenable = 4'hF; m1_write = 1'b1;
    serve(0, 1, 50, st);
    vectors++;
    if (grant_who.size() != 1 || grant_who[0] != 1 || grant_cyc[0] != 1) begin
      miscompares++;
      $display("FAIL drop_then_grant: got %0d grants, required one m1 grant at cycle 1", grant_who.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    test_reset();
    test_single_read();
    test_tie();
    test_write_stall();
    test_rw_both();
    test_spurious();
    test_reset_rdwait();
    test_drop();
    @(posedge clk); #1;
    vectors++;
    if (exp_cmd.size() != 0 || exp_rd0.size() != 0 || exp_rd1.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got cmd=%0d rd0=%0d rd1=%0d pending, required 0 0 0",
               exp_cmd.size(), exp_rd0.size(), exp_rd1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_avl_arbiter.md
CORE_AVL_ARBITER -- requirements
Module: core_avl_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rest  in  1  reset, asynchronous, active-low.
- m0_address / m1_address  in  ADDR_W  master address; m0 is instruction fetch, m1 is load/store unit.
- m0_read / m1_read, m0_write / m1_write  in  1  master read/write command.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
- m0_waitrequest / m1_waitrequest  out  1  command stall to master.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  read data strobe.
- s_address  out  ADDR_W; s_read, s_write  out  1; s_writedata  out  DATA_W; s_byteenable  out  DATA_W/8: shared slave command.
- s_waitrequest  in  1; s_readdata  in  DATA_W; s_readdatavalid  in  1: shared slave response.

Function
REQ-003 SHALL implement states IDLE, CMD, RDWAIT with a 1-bit owner register (0=m0, 1=m1) and a 1-bit last-grant register.
REQ-004 IDLE: a master requests when read or write is high; if exactly one requests, the block SHALL set owner to that master and go to CMD on the next edge.
REQ-005 IDLE, both requesting: the block SHALL grant the master not equal to last-grant (round-robin) and update last-grant to the granted master.
REQ-006 CMD: s_* command outputs SHALL be the owner's inputs, combinationally muxed; the non-owner's command SHALL not reach the slave.
REQ-007 CMD, s_waitrequest=0 with a write: the write is accepted; the block SHALL go to IDLE.
REQ-008 CMD, s_waitrequest=0 with a read: the read is accepted; the block SHALL go to RDWAIT.
REQ-009 Owner waitrequest SHALL equal s_waitrequest in CMD and 1 in every other state; non-owner waitrequest SHALL be 1 always.
REQ-010 Command latency: a request first seen in IDLE at edge N SHALL appear on s_* in the cycle after edge N.
REQ-011 RDWAIT: s_read and s_write SHALL be 0; on s_readdatavalid=1 the block SHALL go to IDLE.
REQ-012 mX_readdata SHALL equal s_readdata for both masters; only the owner's readdatavalid SHALL follow s_readdatavalid, and only in RDWAIT.
REQ-013 s_readdatavalid outside RDWAIT SHALL be ignored: no strobe to either master, no state change.
REQ-014 Only one transaction SHALL be outstanding; no new grant while in CMD or RDWAIT.
REQ-015 Owner asserting read and write together in CMD: s_write SHALL pass, s_read SHALL be forced 0, and the transaction is treated as a write.
REQ-016 Owner dropping both read and write in CMD before acceptance: the block SHALL return to IDLE without issuing a command.
REQ-017 In IDLE: s_read=0, s_write=0, s_address/s_writedata/s_byteenable=0.
REQ-018 Back-to-back requests: after returning to IDLE, the next grant SHALL occur on the following edge (one idle cycle between transactions).

Reset
REQ-019 rest low SHALL asynchronously force state=IDLE, owner=0 and last-grant=1, so m0 wins the first tie.
REQ-020 While rest is low: all s_read/s_write=0, m0/m1_waitrequest=1, m0/m1_readdatavalid=0.
REQ-021 Reset mid-transaction SHALL abandon it; a late s_readdatavalid after reset release SHALL be dropped per REQ-013.

Verification
REQ-022 m0 read 0x100 alone, slave waitrequest 0, readdatavalid 2 cycles later with 0xDEADBEEF -> s_read for exactly one cycle; m0_readdatavalid=1 with 0xDEADBEEF; m1_readdatavalid stays 0.
REQ-023 m0 and m1 request simultaneously after reset -> m0 granted first, m1 next; a repeated tie then grants m1 before m0.
REQ-024 m1 write 0x200 with data 0x55, byteenable 0x3, slave waitrequest high for 3 cycles -> s_write held 4 cycles with stable data; m1_waitrequest mirrors s_waitrequest; m0_waitrequest stays 1.
REQ-025 rest pulsed low while in RDWAIT, then s_readdatavalid arrives -> state IDLE, no readdatavalid to either master, next m1 request granted normally.
REQ-026 Spurious s_readdatavalid in IDLE -> no master strobe, no state change.
REQ-027 m1 read and write asserted together -> slave sees a write only; block returns to IDLE after acceptance.
